// File: rtl/dma_pcie_crdt_pkg.sv
// Shared types and helpers for the credit-gated PCIe transmit mux.
// The counter type uses the default credit width.
package dma_pcie_crdt_pkg;

    localparam int CRDT_BITS_DEF = 5;

    typedef logic [CRDT_BITS_DEF-1:0] crdt_cnt_t;

    // Round-robin successor of ptr in the range 0..n-1.
    function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
        return (ptr + 1 >= n) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/dma_rr_arb.sv
// Combinational round-robin arbiter. Priority starts at rr_ptr and wraps modulo NUM_CH.
// Produces a one-hot grant, its encoded index and an any-grant flag.
module dma_rr_arb #(
    parameter int NUM_CH  = 4,
    parameter int CH_BITS = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0]  req,
    input  logic [CH_BITS-1:0] rr_ptr,
    output logic [NUM_CH-1:0]  gnt,
    output logic [CH_BITS-1:0] gnt_idx,
    output logic               gnt_vld
);

    logic [CH_BITS-1:0] idx;

    always_comb begin
        // NOTE: every output gets a default before the loop, so no path leaves a value unassigned and no latch is inferred.
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        idx     = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = CH_BITS'((int'(rr_ptr) + i) % NUM_CH);
            if (!gnt_vld && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
                gnt_vld  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dma_pcie_crdt_mux.sv
// Credit-gated round-robin transmit mux in front of a PCIe credit interface.
// Per-channel credit counters, the output beat register and the sticky error flag live here.
module dma_pcie_crdt_mux
    import dma_pcie_crdt_pkg::*;
#(
    parameter int DATA_BITS = 512,
    parameter int NUM_CH    = 4,
    parameter int CH_BITS   = $clog2(NUM_CH),
    parameter int CRDT_INIT = 8,
    parameter int CRDT_BITS = CRDT_BITS_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_CH*DATA_BITS-1:0]   in_tdata,
    input  logic [NUM_CH-1:0]             in_tvld,
    output logic [NUM_CH-1:0]             in_trdy,
    output logic [DATA_BITS-1:0]          tl_tdata,
    output logic                          tl_tvld,
    output logic [CH_BITS-1:0]            tl_tch,
    input  logic                          tl_crdt,
    input  logic [CH_BITS-1:0]            tl_crdt_ch,
    input  logic                          crdt_ld,
    output logic [NUM_CH*CRDT_BITS-1:0]   crdt_cnt,
    output logic                          crdt_err
);

    localparam logic [CRDT_BITS-1:0] CRDT_MAX = '1;
    localparam logic [CRDT_BITS-1:0] INIT_VAL = CRDT_BITS'(CRDT_INIT);

    logic [CRDT_BITS-1:0] cnt_q   [NUM_CH];
    logic [DATA_BITS-1:0] ch_data [NUM_CH];
    logic [NUM_CH-1:0]    elig;
    logic [NUM_CH-1:0]    gnt;
    logic [NUM_CH-1:0]    ret_hit;
    logic [NUM_CH-1:0]    ovf;
    logic [CH_BITS-1:0]   rr_ptr;
    logic [CH_BITS-1:0]   gnt_idx;
    logic                 gnt_vld;
    logic                 ret_oor;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign ch_data[g] = in_tdata[g*DATA_BITS +: DATA_BITS];
        assign crdt_cnt[g*CRDT_BITS +: CRDT_BITS] = cnt_q[g];
        assign elig[g]    = in_tvld[g] && (cnt_q[g] != '0);
        assign ret_hit[g] = tl_crdt && (tl_crdt_ch == CH_BITS'(g));
        // A return that coincides with a consume on the same channel nets to zero and cannot overflow.
        assign ovf[g]     = ret_hit[g] && !gnt[g] && (cnt_q[g] == CRDT_MAX);
    end

    assign ret_oor = tl_crdt && (int'(tl_crdt_ch) >= NUM_CH);

    dma_rr_arb #(
        .NUM_CH  (NUM_CH),
        .CH_BITS (CH_BITS)
    ) u_arb (
        .req     (elig),
        .rr_ptr  (rr_ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    assign in_trdy = rst ? '0 : gnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tl_tvld  <= 1'b0;
            tl_tdata <= '0;
            tl_tch   <= '0;
            rr_ptr   <= '0;
        end else begin
            tl_tvld <= gnt_vld;
            if (gnt_vld) begin
                tl_tdata <= ch_data[gnt_idx];
                tl_tch   <= gnt_idx;
                rr_ptr   <= CH_BITS'(rr_next(32'(gnt_idx), NUM_CH));
            end
        end
    end

    // NOTE: the counter array is a handful of flops, not a RAM, so it is reset element by element like any other state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) cnt_q[c] <= INIT_VAL;
        end else if (crdt_ld) begin
            for (int c = 0; c < NUM_CH; c++) cnt_q[c] <= INIT_VAL;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                case ({gnt[c], ret_hit[c]})
                    2'b10:   cnt_q[c] <= cnt_q[c] - 1'b1;
                    2'b01:   if (cnt_q[c] != CRDT_MAX) cnt_q[c] <= cnt_q[c] + 1'b1;
                    default: cnt_q[c] <= cnt_q[c];
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crdt_err <= 1'b0;
        end else if (crdt_ld) begin
            crdt_err <= 1'b0;
        end else if (|ovf || ret_oor) begin
            crdt_err <= 1'b1;
        end
    end

endmodule

// File: doc/dma_pcie_crdt_mux.md
# dma_pcie_crdt_mux

Multi-channel, credit-gated transmit mux placed in front of a `dma_pcie_crdt_if` master port. Up to NUM_CH upstream valid/ready sources are arbitrated round-robin. A beat is only granted when its channel holds at least one credit. Credits return from the PCIe side on `tl_crdt`/`tl_crdt_ch`, which makes this the parametrised, flow-controlled successor to the bare credit interface.

## Interface
- `DATA_BITS`, 512, beat width
- `NUM_CH`, 4, number of channels (2..16)
- `CH_BITS`, `$clog2(NUM_CH)`, channel index width
- `CRDT_INIT`, 8, per-channel credit count loaded at reset and on `crdt_ld`
- `CRDT_BITS`, 5, counter width; CRDT_MAX = 2^CRDT_BITS-1; requires CRDT_INIT ≤ CRDT_MAX

Ports:
- `clk` in 1: single clock
- `rst` in 1: reset, asynchronous, active-high
- `in_tdata` in NUM_CH×DATA_BITS: per-channel beat data
- `in_tvld` in NUM_CH: per-channel valid
- `in_trdy` out NUM_CH: per-channel ready (one-hot or zero)
- `tl_tdata` out DATA_BITS: granted beat
- `tl_tvld` out 1: beat valid; sink accepts unconditionally
- `tl_tch` out CH_BITS: channel of beat
- `tl_crdt` in 1: one-credit return strobe
- `tl_crdt_ch` in CH_BITS: channel of returned credit
- `crdt_ld` in 1: synchronous reload of all counters to CRDT_INIT
- `crdt_cnt` out NUM_CH×CRDT_BITS: current credit counts
- `crdt_err` out 1: sticky; set on overflow or on return to out-of-range channel

## Operation
- Eligible[c] = `in_tvld[c]` && `crdt_cnt[c]` != 0.
- The round-robin arbiter picks one eligible channel. Priority starts at `rr_ptr` and wraps modulo NUM_CH.
- `in_trdy[c]` = grant[c]. It is combinational from `in_tvld`, the counters and `rr_ptr`, and is never asserted for a channel with zero credit.
- Handshake (`in_tvld[c]` && `in_trdy[c]`):
  - capture data and channel into the output register;
  - `crdt_cnt[c]` -= 1;
  - `rr_ptr` = c+1 mod NUM_CH.
- No handshake: `tl_tvld` = 0 next cycle and `rr_ptr` holds.
- Credit return (`tl_crdt`) with `tl_crdt_ch` < NUM_CH: the counter for that channel += 1.
  - If it is already CRDT_MAX, it saturates and `crdt_err` is set.
  - If `tl_crdt_ch` ≥ NUM_CH (non-power-of-2 NUM_CH), the return is ignored and `crdt_err` is set.
- Same-cycle consume and return on the same channel: net count unchanged, no error even at CRDT_MAX.
- `crdt_ld` overrides same-cycle consume and return: all counters are loaded with CRDT_INIT and `crdt_err` is cleared. A handshake in that cycle still emits its beat.
- `crdt_cnt` holds only committed credits. Beats stay in the output register for one cycle, and there is no backpressure path.

## Timing
- Reset values:
  - `tl_tvld` = 0, `tl_tdata` = 0, `tl_tch` = 0;
  - `crdt_cnt[*]` = CRDT_INIT, `rr_ptr` = 0, `crdt_err` = 0.
  - `in_trdy` = 0 while `rst` is high.
- Latency: a handshake at edge N produces `tl_tvld` = 1 with data for cycles N..N+1. Throughput is 1 beat/cycle.
- Credit update takes effect at the clock edge. A credit returned at edge N can enable a grant in the following cycle; there is no combinational `tl_crdt` → `in_trdy` path.
- Reset asserted mid-stream: outputs clear asynchronously and any in-flight output beat is dropped. Counters return to CRDT_INIT, and upstream must treat outstanding credits as lost.
- Upstream rule: `in_tdata[c]` stays stable while `in_tvld[c]` is high and not yet granted.

## Structure
- Package `dma_pcie_crdt_pkg`:
  - `CRDT_BITS` default;
  - typedef `crdt_cnt_t`;
  - `function automatic rr_next(ptr, n)`.
- Sub-module `dma_rr_arb` (NUM_CH request, `rr_ptr` → one-hot grant plus encoded index). It is purely combinational and is instantiated once.
- Counters, output register and error flag live in the top module.

## Test plan
- Reset release, CRDT_INIT=8, ch0 valid continuously, no returns → exactly 8 beats on `tl_tch`=0 in 8 consecutive cycles, then `in_trdy[0]`=0 and `crdt_cnt[0]`=0.
- All 4 channels valid with full credits → `tl_tch` sequence 0,1,2,3,0,1,… at 1 beat/cycle.
- ch2 at 0 credits, others valid → ch2 is skipped. Pulse `tl_crdt` with ch=2 at edge N → ch2 granted no earlier than cycle N+1, and only when `rr_ptr` reaches it.
- ch1 at CRDT_MAX=31:
  - return a credit → count stays 31 and `crdt_err`=1;
  - `crdt_ld` → all counts 8 and `crdt_err`=0.
- ch3 at count 5, handshake plus `tl_crdt` on ch3 in the same cycle → count stays 5. The same case at 31 → count stays 31 with no error.
- Assert `rst` while beats are streaming → `tl_tvld` drops immediately and all counts read 8 after release.
